reg_rename_file: RTL and testbench
==================================

# reg_rename_file

Architectural register file with per-register rename tags for the out-of-order RV32 core. It sits between the decoder and the reorder buffer. It accepts in-order commits and new destination renames from the reorder buffer, and answers the decoder's two source-operand lookups each cycle. For a source whose producer is still in flight it queries the reorder buffer by tag, so the decoder receives either a final value or a reorder-buffer ID to wait on.

## Interface
- ROB_WIDTH_BIT, default 4; width of reorder-buffer IDs. It must equal the reorder buffer's setting.
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  pause when low: no state update; combinational outputs stay valid
- clear  input  1  flush from the reorder buffer; all rename tags are discarded
- commit_reg_id  input  5  register written at commit; 0 means no commit
- commit_val  input  32  committed value
- commit_rob_id  input  ROB_WIDTH_BIT  reorder-buffer ID of the committing entry
- dep_reg_id  input  5  destination register being renamed; 0 means none
- dep_rob_id  input  ROB_WIDTH_BIT  new producer ID for dep_reg_id
- rs1_id, rs2_id  input  5 each  decoder source registers
- rs1_val, rs2_val  output  32 each  operand value; valid when the matching has_dep is 0
- rs1_has_dep, rs2_has_dep  output  1 each  operand still pending
- rs1_dep, rs2_dep  output  ROB_WIDTH_BIT each  producer ID to wait on; 0 when has_dep is 0
- get_rob_id1, get_rob_id2  output  ROB_WIDTH_BIT each  tag query to the reorder buffer
- rob_value1_ready, rob_value2_ready  input  1 each  queried entry has its result
- rob_value1, rob_value2  input  32 each  result of the queried entry

## Operation
- State per register r = 1..31:
  - val[r]: 32 bits.
  - busy[r]: 1 bit.
  - tag[r]: ROB_WIDTH_BIT bits.
- Register x0 is hardwired: it has no state, reads return 0 with has_dep = 0, and commits or renames to x0 are ignored.
- Read path (combinational, identical for ports 1 and 2; shown for port 1 with r = rs1_id):
  - get_rob_id1 = tag[r] if busy[r], else 0.
  - If r = 0, or busy[r] = 0: return val[r] (0 for x0), has_dep = 0.
  - Else, if commit_reg_id = r and commit_rob_id = tag[r]: return commit_val, has_dep = 0 (same-cycle commit forward).
  - Else, if rob_value1_ready: return rob_value1, has_dep = 0.
  - Else: has_dep = 1, rs1_dep = tag[r], rs1_val = 0.
  - Reads ignore this cycle's rename: the decoder reads its sources before renaming its own destination, so rd = rs1 in the same instruction sees the old producer.
- Update at posedge, in priority order:
  1. rst_in: val, busy and tag of every register cleared to 0.
  2. clear: busy and tag of every register cleared to 0; val is kept; this cycle's commit and rename are ignored, because they are wrong-path.
  3. rdy_in = 0: no change.
  4. Otherwise, in this order:
     - Commit (commit_reg_id ≠ 0): val[commit_reg_id] <= commit_val, unconditionally. If busy and tag equals commit_rob_id, clear busy. If the tag differs, a younger producer owns the register and busy stays set.
     - Rename (dep_reg_id ≠ 0): busy <= 1, tag <= dep_rob_id. A rename overrides the commit's busy-clear when both target the same register.

## Timing
- Read latency: 0 cycles, purely combinational from rs*_id and the reorder-buffer responses.
- Commit and rename become visible in stored state on the cycle after the clock edge. The commit value is visible in the same cycle through the forward path.
- Reset values: all outputs are 0 once rst_in has been sampled, and rs*_has_dep = 0 for every rs*_id.
- Simultaneous events:
  - Commit and rename to the same register: value updated, busy = 1, tag = dep_rob_id.
  - Commit and clear in the same cycle: commit dropped.
  - Tag wrap-around is harmless. An ID is reissued only after its entry has retired, and the commit tag compare prevents a stale clear of busy.

## Test plan
- Reset, then read rs1 = 5, rs2 = 0 -> vals 0, both has_dep 0, get_rob_id1 = 0.
- Rename x5→ID 3, then read x5 with rob_value1_ready = 0 -> has_dep = 1, dep = 3, get_rob_id1 = 3. Then raise rob_value1_ready with rob_value1 = 0x1234 -> val 0x1234, has_dep 0.
- Rename x7→ID 2, next cycle commit x7 = 0xABCD with ID 2 while reading x7 -> same cycle val 0xABCD, has_dep 0; the cycle after, busy clear and val 0xABCD.
- Rename x7→ID 2, then x7→ID 6, then commit x7 ID 2 = 0x11 -> val 0x11, busy stays, dep = 6. Commit and rename of x9 in the same cycle -> busy 1 with the new tag.
- Three renames, then clear together with a commit of x4 = 0x99 -> all has_dep 0 next cycle, x4 keeps its old value, and earlier committed values persist.
- With rdy_in = 0, apply commit and rename -> no state change. Commit to x0 -> x0 still reads 0.

Source files
------------

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags.
// Two combinational source lookups with commit forwarding and reorder-buffer value bypass.

module reg_rename_rd #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic [4:0]                     rs_id,
  input  logic [31:1][31:0]              val_q,
  input  logic [31:1]                    busy_q,
  input  logic [31:1][ROB_WIDTH_BIT-1:0] tag_q,
  input  logic [4:0]                     commit_reg_id,
  input  logic [31:0]                    commit_val,
  input  logic [ROB_WIDTH_BIT-1:0]       commit_rob_id,
  input  logic                           rob_ready,
  input  logic [31:0]                    rob_value,
  output logic [31:0]                    rs_val,
  output logic                           has_dep,
  output logic [ROB_WIDTH_BIT-1:0]       dep,
  output logic [ROB_WIDTH_BIT-1:0]       get_rob_id
);
  logic [31:0]              sel_val;
  logic                     sel_busy;
  logic [ROB_WIDTH_BIT-1:0] sel_tag;

  // x0 never matches, so it reads as value 0 and not busy
  always_comb begin
    sel_val  = '0;
    sel_busy = 1'b0;
    sel_tag  = '0;
    for (int r = 1; r < 32; r++) begin
      if (rs_id == 5'(r)) begin
        sel_val  = val_q[r];
        sel_busy = busy_q[r];
        sel_tag  = tag_q[r];
      end
    end
  end

  always_comb begin
    get_rob_id = sel_busy ? sel_tag : '0;
    rs_val     = sel_val;
    has_dep    = 1'b0;
    dep        = '0;
    if (sel_busy) begin
      if (commit_reg_id == rs_id && commit_rob_id == sel_tag) begin
        rs_val = commit_val;
      end else if (rob_ready) begin
        rs_val = rob_value;
      end else begin
        rs_val  = '0;
        has_dep = 1'b1;
        dep     = sel_tag;
      end
    end
  end
endmodule

module reg_rename_file #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [4:0]               commit_reg_id,
  input  logic [31:0]              commit_val,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [4:0]               dep_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] dep_rob_id,
  input  logic [4:0]               rs1_id,
  input  logic [4:0]               rs2_id,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic                     rs1_has_dep,
  output logic                     rs2_has_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs2_dep,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  input  logic                     rob_value1_ready,
  input  logic                     rob_value2_ready,
  input  logic [31:0]              rob_value1,
  input  logic [31:0]              rob_value2
);
  localparam int NUM_PORTS = 2;

  logic [31:1][31:0]              val_q;
  logic [31:1]                    busy_q;
  logic [31:1][ROB_WIDTH_BIT-1:0] tag_q;

  // Rename is written after commit so it wins the busy/tag update on a shared register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else if (clear) begin
      busy_q <= '0;
      tag_q  <= '0;
    end else if (rdy_in) begin
      for (int r = 1; r < 32; r++) begin
        if (commit_reg_id == 5'(r)) begin
          val_q[r] <= commit_val;
          if (busy_q[r] && tag_q[r] == commit_rob_id) busy_q[r] <= 1'b0;
        end
        if (dep_reg_id == 5'(r)) begin
          busy_q[r] <= 1'b1;
          tag_q[r]  <= dep_rob_id;
        end
      end
    end
  end

  logic [NUM_PORTS-1:0][4:0]               rs_id;
  logic [NUM_PORTS-1:0]                    rob_ready;
  logic [NUM_PORTS-1:0][31:0]              rob_value;
  logic [NUM_PORTS-1:0][31:0]              rs_val;
  logic [NUM_PORTS-1:0]                    has_dep;
  logic [NUM_PORTS-1:0][ROB_WIDTH_BIT-1:0] dep;
  logic [NUM_PORTS-1:0][ROB_WIDTH_BIT-1:0] get_id;

  assign rs_id     = {rs2_id, rs1_id};
  assign rob_ready = {rob_value2_ready, rob_value1_ready};
  assign rob_value = {rob_value2, rob_value1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    reg_rename_rd #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT)) u_rd (
      .rs_id         (rs_id[p]),
      .val_q         (val_q),
      .busy_q        (busy_q),
      .tag_q         (tag_q),
      .commit_reg_id (commit_reg_id),
      .commit_val    (commit_val),
      .commit_rob_id (commit_rob_id),
      .rob_ready     (rob_ready[p]),
      .rob_value     (rob_value[p]),
      .rs_val        (rs_val[p]),
      .has_dep       (has_dep[p]),
      .dep           (dep[p]),
      .get_rob_id    (get_id[p])
    );
  end

  assign rs1_val     = rs_val[0];
  assign rs2_val     = rs_val[1];
  assign rs1_has_dep = has_dep[0];
  assign rs2_has_dep = has_dep[1];
  assign rs1_dep     = dep[0];
  assign rs2_dep     = dep[1];
  assign get_rob_id1 = get_id[0];
  assign get_rob_id2 = get_id[1];
endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: directed scenarios then random traffic,
// expected read results queued by the driver and checked by a separate monitor.
module tb_reg_rename_file;
  localparam int W = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear;
  logic [4:0]    commit_reg_id, dep_reg_id, rs1_id, rs2_id;
  logic [31:0]   commit_val, rs1_val, rs2_val, rob_value1, rob_value2;
  logic [W-1:0]  commit_rob_id, dep_rob_id, rs1_dep, rs2_dep, get_rob_id1, get_rob_id2;
  logic          rs1_has_dep, rs2_has_dep, rob_value1_ready, rob_value2_ready;

  always #5 clk_in = ~clk_in;

  reg_rename_file #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .dep_reg_id(dep_reg_id), .dep_rob_id(dep_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_has_dep(rs1_has_dep), .rs2_has_dep(rs2_has_dep),
    .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
    .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
    .rob_value1(rob_value1), .rob_value2(rob_value2)
  );

  typedef struct packed {
    logic [31:0]  v;
    logic         hd;
    logic [W-1:0] dep;
    logic [W-1:0] get;
  } port_t;

  typedef struct packed {
    port_t p2;
    port_t p1;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   model_init = 0;

  // Reference state: what each architectural register holds and who owns it
  logic [31:0]  mval [32];
  bit           mbusy[32];
  logic [W-1:0] mtag [32];

  function automatic port_t mread(input logic [4:0] r, input logic rr, input logic [31:0] rv);
    port_t e;
    e = '0;
    if (r == 5'd0 || !mbusy[r]) begin
      e.v = (r == 5'd0) ? 32'd0 : mval[r];
    end else begin
      e.get = mtag[r];
      if (commit_reg_id == r && commit_rob_id == mtag[r]) e.v = commit_val;
      else if (rr) e.v = rv;
      else begin
        e.hd  = 1'b1;
        e.dep = mtag[r];
      end
    end
    return e;
  endfunction

  task automatic model_step();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin mval[i] = '0; mbusy[i] = 0; mtag[i] = '0; end
      model_init = 1;
    end else if (clear) begin
      for (int i = 0; i < 32; i++) begin mbusy[i] = 0; mtag[i] = '0; end
    end else if (rdy_in) begin
      if (commit_reg_id != 5'd0) begin
        mval[commit_reg_id] = commit_val;
        if (mbusy[commit_reg_id] && mtag[commit_reg_id] == commit_rob_id) mbusy[commit_reg_id] = 0;
      end
      if (dep_reg_id != 5'd0) begin
        mbusy[dep_reg_id] = 1;
        mtag[dep_reg_id]  = dep_rob_id;
      end
    end
  endtask

  task automatic defaults();
    rst_in = 0; rdy_in = 1; clear = 0;
    commit_reg_id = 0; commit_val = 0; commit_rob_id = 0;
    dep_reg_id = 0; dep_rob_id = 0; rs1_id = 0; rs2_id = 0;
    rob_value1_ready = 0; rob_value2_ready = 0; rob_value1 = 0; rob_value2 = 0;
  endtask

  // Inputs are set by the caller shortly after a posedge; queue the read the monitor will see
  task automatic step();
    exp_t e;
    #1;
    if (model_init) begin
      e.p1 = mread(rs1_id, rob_value1_ready, rob_value1);
      e.p2 = mread(rs2_id, rob_value2_ready, rob_value2);
      q.push_back(e);
    end
    @(posedge clk_in);
    model_step();
    #1;
    defaults();
  endtask

  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t  e;
      port_t a1, a2;
      e  = q.pop_front();
      a1 = {rs1_val, rs1_has_dep, rs1_dep, get_rob_id1};
      a2 = {rs2_val, rs2_has_dep, rs2_dep, get_rob_id2};
      compared += 2;
      if (a1 !== e.p1) begin
        mismatched++;
        $display("FAIL port1 rs1=%0d got val=%h dep=%b/%0d get=%0d want val=%h dep=%b/%0d get=%0d",
                 rs1_id, a1.v, a1.hd, a1.dep, a1.get, e.p1.v, e.p1.hd, e.p1.dep, e.p1.get);
      end
      if (a2 !== e.p2) begin
        mismatched++;
        $display("FAIL port2 rs2=%0d got val=%h dep=%b/%0d get=%0d want val=%h dep=%b/%0d get=%0d",
                 rs2_id, a2.v, a2.hd, a2.dep, a2.get, e.p2.v, e.p2.hd, e.p2.dep, e.p2.get);
      end
    end
  end

  initial begin
    defaults();
    @(posedge clk_in); #1;
    rst_in = 1; step();

    // reset state
    rs1_id = 5; rs2_id = 0; step();
    // rename then wait / bypass from the reorder buffer
    dep_reg_id = 5; dep_rob_id = 3; step();
    rs1_id = 5; rs2_id = 5; step();
    rs1_id = 5; rob_value1_ready = 1; rob_value1 = 32'h1234; step();
    // commit forward in the same cycle, then stored
    dep_reg_id = 7; dep_rob_id = 2; step();
    commit_reg_id = 7; commit_val = 32'hABCD; commit_rob_id = 2; rs1_id = 7; rs2_id = 7; step();
    rs1_id = 7; step();
    // stale commit keeps the younger owner; commit+rename on one register
    dep_reg_id = 7; dep_rob_id = 2; step();
    dep_reg_id = 7; dep_rob_id = 6; step();
    commit_reg_id = 7; commit_val = 32'h11; commit_rob_id = 2; rs1_id = 7; step();
    rs1_id = 7; rs2_id = 7; step();
    commit_reg_id = 9; commit_val = 32'h55; commit_rob_id = 1; dep_reg_id = 9; dep_rob_id = 4; step();
    rs1_id = 9; rs2_id = 9; rob_value2_ready = 1; rob_value2 = 32'hBEEF; step();
    // flush drops the same-cycle commit
    commit_reg_id = 4; commit_val = 32'h44; step();
    dep_reg_id = 4; dep_rob_id = 1; step();
    dep_reg_id = 10; dep_rob_id = 2; step();
    dep_reg_id = 11; dep_rob_id = 3; step();
    clear = 1; commit_reg_id = 4; commit_val = 32'h99; commit_rob_id = 1; step();
    rs1_id = 4; rs2_id = 10; step();
    rs1_id = 11; rs2_id = 7; step();
    // stall, and x0 is inert
    rdy_in = 0; commit_reg_id = 12; commit_val = 32'h77; dep_reg_id = 13; dep_rob_id = 5; step();
    rs1_id = 12; rs2_id = 13; step();
    rs1_id = 0; rs2_id = 0; dep_reg_id = 0; step();

    // random traffic on a small register window to force collisions
    for (int n = 0; n < 2000; n++) begin
      rst_in = ($urandom_range(0, 499) == 0);
      clear  = ($urandom_range(0, 99) < 4);
      rdy_in = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 60) begin
        commit_reg_id = 5'($urandom_range(1, 15));
        commit_rob_id = ($urandom_range(0, 1) == 1) ? mtag[commit_reg_id] : W'($urandom);
        commit_val    = $urandom;
      end
      if ($urandom_range(0, 99) < 50) begin
        dep_reg_id = 5'($urandom_range(0, 15));
        dep_rob_id = W'($urandom);
      end
      rs1_id = 5'($urandom_range(0, 15));
      rs2_id = 5'($urandom_range(0, 15));
      rob_value1_ready = ($urandom_range(0, 2) == 0);
      rob_value2_ready = ($urandom_range(0, 2) == 0);
      rob_value1 = $urandom;
      rob_value2 = $urandom;
      step();
    end

    repeat (3) @(posedge clk_in);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
